// File: rtl/bin_bcd_ascii_seq.sv
// rtl/bin_bcd_ascii_seq.sv - sequential double-dabble binary to BCD/ASCII converter
// One binary bit is consumed per clock; results are held until the consumer accepts them.
module bin_bcd_ascii_seq #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int LZ_BLANK = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [8*DIGITS-1:0]   out_ascii,
  output logic                  out_ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_next;
  logic [BW-1:0]     acc;
  logic [WIDTH-1:0]  sh;
  logic [CW-1:0]     count;
  logic              ovf_q;

  logic [BW-1:0]        acc_adj;
  logic [BW-1:0]        acc_next;
  logic                 carry;
  logic                 last;
  logic [8*DIGITS-1:0]  ascii_next;

  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction before the shift keeps every nibble a valid decimal digit afterwards.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    carry    = acc_adj[BW-1];
    acc_next = {acc_adj[BW-2:0], sh[WIDTH-1]};
  end

  always_comb begin
    logic       nz;
    logic [3:0] d;
    nz         = 1'b0;
    d          = 4'd0;
    ascii_next = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = acc_next[4*i +: 4];
      if (LZ_BLANK != 0 && i > 0 && !nz && d == 4'd0)
        ascii_next[8*i +: 8] = 8'h20;
      else
        ascii_next[8*i +: 8] = 8'h30 + {4'h0, d};
      nz = nz | (d != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sh        <= '0;
      count     <= '0;
      ovf_q     <= 1'b0;
      out_bcd   <= '0;
      out_ascii <= {DIGITS{8'h30}};
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= in_data;
            acc   <= '0;
            ovf_q <= 1'b0;
            count <= '0;
          end
        end
        SHIFT: begin
          acc   <= acc_next;
          sh    <= {sh[WIDTH-2:0], 1'b0};
          ovf_q <= ovf_q | carry;
          count <= count + CW'(1);
          if (last) begin
            out_bcd   <= acc_next;
            out_ascii <= ascii_next;
            out_ovf   <= ovf_q | carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_bcd_ascii_seq.sv
// tb/tb_bin_bcd_ascii_seq.sv - scoreboard bench for bin_bcd_ascii_seq over four parameter sets
module tb_bin_bcd_ascii_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [19:0] bcd;
    logic [39:0] ascii;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];

  logic [15:0] in_data_a   [4];
  logic        in_valid_a  [4];
  logic        out_ready_a [4];
  logic [19:0] bcd_a       [4];
  logic [39:0] ascii_a     [4];
  logic        ovf_a       [4];
  logic        ov_a        [4];
  logic        ir_a        [4];

  logic [11:0] b0; logic [23:0] a0; logic f0, v0, r0;
  logic [11:0] b1; logic [23:0] a1; logic f1, v1, r1;
  logic [19:0] b2; logic [39:0] a2; logic f2, v2, r2;
  logic [7:0]  b3; logic [15:0] a3; logic f3, v3, r3;

  bin_bcd_ascii_seq #(.WIDTH(8), .DIGITS(3), .LZ_BLANK(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data_a[0][7:0]), .in_valid(in_valid_a[0]),
    .in_ready(r0), .out_bcd(b0), .out_ascii(a0), .out_ovf(f0), .out_valid(v0),
    .out_ready(out_ready_a[0]));
  bin_bcd_ascii_seq #(.WIDTH(8), .DIGITS(3), .LZ_BLANK(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data_a[1][7:0]), .in_valid(in_valid_a[1]),
    .in_ready(r1), .out_bcd(b1), .out_ascii(a1), .out_ovf(f1), .out_valid(v1),
    .out_ready(out_ready_a[1]));
  bin_bcd_ascii_seq #(.WIDTH(16), .DIGITS(5), .LZ_BLANK(0)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data_a[2]), .in_valid(in_valid_a[2]),
    .in_ready(r2), .out_bcd(b2), .out_ascii(a2), .out_ovf(f2), .out_valid(v2),
    .out_ready(out_ready_a[2]));
  bin_bcd_ascii_seq #(.WIDTH(8), .DIGITS(2), .LZ_BLANK(0)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data_a[3][7:0]), .in_valid(in_valid_a[3]),
    .in_ready(r3), .out_bcd(b3), .out_ascii(a3), .out_ovf(f3), .out_valid(v3),
    .out_ready(out_ready_a[3]));

  assign bcd_a[0] = 20'(b0); assign ascii_a[0] = 40'(a0);
  assign bcd_a[1] = 20'(b1); assign ascii_a[1] = 40'(a1);
  assign bcd_a[2] = b2;      assign ascii_a[2] = a2;
  assign bcd_a[3] = 20'(b3); assign ascii_a[3] = 40'(a3);
  assign ovf_a[0] = f0; assign ovf_a[1] = f1; assign ovf_a[2] = f2; assign ovf_a[3] = f3;
  assign ov_a[0]  = v0; assign ov_a[1]  = v1; assign ov_a[2]  = v2; assign ov_a[3]  = v3;
  assign ir_a[0]  = r0; assign ir_a[1]  = r1; assign ir_a[2]  = r2; assign ir_a[3]  = r3;

  function automatic int w_of(input int idx);
    return (idx == 2) ? 16 : 8;
  endfunction

  function automatic int d_of(input int idx);
    case (idx)
      2:       return 5;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [39:0] reset_ascii(input int idx);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < d_of(idx); i++) r[8*i +: 8] = 8'h30;
    return r;
  endfunction

  // Reference: decimal digits by division, blanking decided from the numeric value above each digit.
  function automatic exp_t model(input int idx, input int unsigned v);
    exp_t        e;
    int unsigned p, top, d, hi;
    e.idx   = idx;
    e.bcd   = '0;
    e.ascii = '0;
    e.acc   = 0;
    top = 1;
    for (int i = 0; i < d_of(idx); i++) top = top * 10;
    e.ovf = (v >= top);
    p = 1;
    for (int i = 0; i < d_of(idx); i++) begin
      d  = (v / p) % 10;
      hi = (v % top) / (p * 10);
      e.bcd[4*i +: 4] = 4'(d);
      if (idx == 1 && i > 0 && d == 0 && hi == 0) e.ascii[8*i +: 8] = 8'h20;
      else                                         e.ascii[8*i +: 8] = 8'h30 + 8'(d);
      p = p * 10;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d got=%h expected=%h t=%0t", name, idx, got, exp, $time);
    end
  endtask

  bit          prev_v  [4];
  bit          prev_hs [4];
  logic [19:0] pb      [4];
  logic [39:0] pa      [4];
  logic        po      [4];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        prev_v[i]  = 1'b0;
        prev_hs[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (prev_hs[i]) chk("idle_after_accept", i, {ir_a[i], ov_a[i]}, 2'b10);
        if (ov_a[i]) begin
          chk("in_ready_low_in_done", i, ir_a[i], 0);
          if (!prev_v[i]) begin
            if (q.size() == 0 || q[0].idx != i) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid dut=%0d got=1 expected=0 t=%0t", i, $time);
            end else begin
              chk("latency", i, cyc - q[0].acc, w_of(i));
            end
          end else if (!prev_hs[i]) begin
            chk("stable_while_stalled", i, {bcd_a[i], ascii_a[i], ovf_a[i]}, {pb[i], pa[i], po[i]});
          end
          if (out_ready_a[i] && q.size() > 0 && q[0].idx == i) begin
            chk("out_bcd", i, bcd_a[i], q[0].bcd);
            chk("out_ascii", i, ascii_a[i], q[0].ascii);
            chk("out_ovf", i, ovf_a[i], q[0].ovf);
            void'(q.pop_front());
          end
        end
        prev_v[i]  = ov_a[i];
        prev_hs[i] = ov_a[i] && out_ready_a[i];
        pb[i] = bcd_a[i];
        pa[i] = ascii_a[i];
        po[i] = ovf_a[i];
      end
    end
  end

  task automatic convert(input int idx, input int unsigned v, input int stall_max,
                         input bit noise, input bit early);
    int   t;
    int   n;
    exp_t e;
    t = 0;
    while (!ir_a[idx] && t < 50) begin @(posedge clk); #1; t++; end
    if (!ir_a[idx]) begin chk("idle_timeout", idx, 0, 1); return; end
    e     = model(idx, v);
    e.acc = cyc + 1;
    q.push_back(e);
    in_data_a[idx]   = 16'(v);
    in_valid_a[idx]  = 1'b1;
    out_ready_a[idx] = early ? 1'b1 : 1'($urandom);
    @(posedge clk); #1;
    in_valid_a[idx] = 1'b0;
    t = 0;
    while (!ov_a[idx] && t < 40) begin
      if (noise) begin
        in_valid_a[idx] = 1'($urandom);
        in_data_a[idx]  = 16'($urandom);
      end
      out_ready_a[idx] = early ? 1'b1 : 1'($urandom);
      @(posedge clk); #1; t++;
    end
    if (!ov_a[idx]) begin
      chk("valid_timeout", idx, 0, 1);
      q.delete();
      in_valid_a[idx] = 1'b0;
      return;
    end
    n = (stall_max == 0) ? 0 : $urandom_range(0, stall_max);
    if (n > 0) out_ready_a[idx] = 1'b0;
    repeat (n) begin
      if (noise) begin
        in_valid_a[idx] = 1'($urandom);
        in_data_a[idx]  = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid_a[idx]  = 1'b0;
    out_ready_a[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[idx] = early ? 1'b1 : 1'b0;
  endtask

  int l1[4] = '{0, 7, 40, 100};
  int l2[4] = '{65535, 9999, 0, 10000};
  int l3[5] = '{123, 255, 99, 100, 0};

  initial begin
    #2ms;
    $display("FAIL watchdog dut=- got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      in_data_a[i]   = '0;
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("reset_handshake", i, {ir_a[i], ov_a[i]}, 2'b10);
      chk("reset_bcd", i, bcd_a[i], 0);
      chk("reset_ascii", i, ascii_a[i], reset_ascii(i));
      chk("reset_ovf", i, ovf_a[i], 0);
    end

    convert(0, 255, 0, 1'b0, 1'b1);
    for (int v = 0; v < 256; v++) convert(0, v, 5, (v % 3) == 0, 1'b0);

    foreach (l1[k]) convert(1, l1[k], 2, 1'b1, 1'b0);
    repeat (6) convert(1, $urandom_range(0, 255), 3, 1'b0, 1'b0);

    foreach (l2[k]) convert(2, l2[k], 2, 1'b1, 1'b0);
    repeat (6) convert(2, $urandom_range(0, 65535), 3, 1'b0, 1'b1);

    foreach (l3[k]) convert(3, l3[k], 2, 1'b1, 1'b0);
    repeat (6) convert(3, $urandom_range(0, 255), 3, 1'b0, 1'b0);

    // Abort a conversion of 200 part-way; nothing from it may ever appear.
    in_data_a[0]  = 16'd200;
    in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_handshake", 0, {ir_a[0], ov_a[0]}, 2'b10);
    chk("abort_bcd", 0, bcd_a[0], 0);
    chk("abort_ascii", 0, ascii_a[0], 40'h303030);
    chk("abort_ovf", 0, ovf_a[0], 0);
    repeat (12) @(posedge clk);
    #1;
    convert(0, 45, 1, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 0, q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
